// File: rtl/line_fifo.sv
// line_fifo
//
// Single-clock line FIFO between the BT.656 decoder and the Avalon-ST output
// stage. Whole video lines are buffered in NUM_LINES slots of LINE_SIZE words.
// The writer commits a line only after its last word is stored, so the reader
// never sees a partial or torn line. A line that starts while every slot is
// occupied is dropped whole. A line that is still being written can be
// abandoned with line_abort.
//
// Optional feature: define LINE_FIFO_DROP_CNT_EN to build the saturating
// drop counter. Without it, drop_count is tied to zero.
//
// Ports:
//   clock       single clock, all logic on the rising edge
//   reset       synchronous, active-high
//   data_in     write word
//   write       write strobe, one word per cycle
//   line_abort  discard the line currently being written (wins over write)
//   read        read strobe, one word per cycle
//   data_out    registered read word
//   data_valid  data_out holds a word read on the previous edge
//   full        lines_used == NUM_LINES
//   empty       lines_used == 0
//   lines_used  committed lines not yet fully read
//   overflow    one-cycle pulse after a line start is dropped
//   drop_count  saturating count of dropped lines (0 unless enabled)

module line_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_SIZE  = 720,
  parameter int NUM_LINES  = 5
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               write,
  input  logic                               line_abort,
  input  logic                               read,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_valid,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(NUM_LINES+1)-1:0]     lines_used,
  output logic                               overflow,
  output logic [15:0]                        drop_count
);

  localparam int CNT_W  = $clog2(NUM_LINES + 1);
  localparam int SLOT_W = $clog2(NUM_LINES);
  localparam int PX_W   = $clog2(LINE_SIZE);
  localparam int DEPTH  = NUM_LINES * LINE_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [PX_W-1:0]   LAST_PX   = PX_W'(LINE_SIZE - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_LINES);

  typedef enum logic {
    FILL,
    DROP
  } wr_state_t;

  wr_state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [SLOT_W-1:0] head;
  logic [SLOT_W-1:0] tail;
  logic [PX_W-1:0]   wr_px;
  logic [PX_W-1:0]   wr_px_next;
  logic [PX_W-1:0]   rd_px;
  logic [CNT_W-1:0]  lines_next;

  logic store_en;
  logic commit;
  logic drop_start;
  logic rd_accept;
  logic rd_done;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_addr = ADDR_W'(head) * ADDR_W'(LINE_SIZE) + ADDR_W'(wr_px);
  assign rd_addr = ADDR_W'(tail) * ADDR_W'(LINE_SIZE) + ADDR_W'(rd_px);

  // Reads are gated by the registered empty flag, so a freshly committed line
  // becomes readable one edge after its last word is written.
  assign rd_accept = read && !empty;
  assign rd_done   = rd_accept && (rd_px == LAST_PX);

  // Write FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Write FSM next state. The full check uses the registered count, so a
  // line start that coincides with a reader finishing a line is still
  // dropped; its next start sees the freed slot.
  always_comb begin
    state_next = state;
    wr_px_next = wr_px;
    store_en   = 1'b0;
    commit     = 1'b0;
    drop_start = 1'b0;
    if (line_abort) begin
      state_next = FILL;
      wr_px_next = '0;
    end else if (write) begin
      unique case (state)
        FILL: begin
          if (wr_px == '0 && full) begin
            state_next = DROP;
            wr_px_next = PX_W'(1);
            drop_start = 1'b1;
          end else begin
            store_en = 1'b1;
            if (wr_px == LAST_PX) begin
              commit     = 1'b1;
              wr_px_next = '0;
            end else begin
              wr_px_next = wr_px + PX_W'(1);
            end
          end
        end
        DROP: begin
          if (wr_px == LAST_PX) begin
            state_next = FILL;
            wr_px_next = '0;
          end else begin
            wr_px_next = wr_px + PX_W'(1);
          end
        end
        default: begin
          state_next = FILL;
          wr_px_next = '0;
        end
      endcase
    end
  end

  // Write-side pointers. An abort leaves head alone, so the slot is reused.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_px <= '0;
      head  <= '0;
    end else begin
      wr_px <= wr_px_next;
      if (commit) begin
        head <= (head == LAST_SLOT) ? '0 : head + SLOT_W'(1);
      end
    end
  end

  // Line storage has no reset. Only the pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (store_en && !reset) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Read-side pointers and the registered output word.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_px      <= '0;
      tail       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_accept;
      if (rd_accept) begin
        data_out <= mem[rd_addr];
        rd_px    <= (rd_px == LAST_PX) ? '0 : rd_px + PX_W'(1);
        if (rd_done) begin
          tail <= (tail == LAST_SLOT) ? '0 : tail + SLOT_W'(1);
        end
      end
    end
  end

  // A commit and a read-line completion on the same edge cancel out.
  always_comb begin
    lines_next = lines_used;
    if (commit && !rd_done) begin
      lines_next = lines_used + CNT_W'(1);
    end else if (!commit && rd_done) begin
      lines_next = lines_used - CNT_W'(1);
    end
  end

  // The occupancy flags are derived from the same next value, so they never
  // disagree with lines_used.
  always_ff @(posedge clock) begin
    if (reset) begin
      lines_used <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      lines_used <= lines_next;
      full       <= (lines_next == FULL_CNT);
      empty      <= (lines_next == '0);
      overflow   <= drop_start;
    end
  end

`ifdef LINE_FIFO_DROP_CNT_EN
  logic drop_done;

  assign drop_done = (state == DROP) && write && !line_abort && (wr_px == LAST_PX);

  // A dropped line counts once its last word has gone by.
  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_done && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_line_fifo.sv
// tb_line_fifo
//
// Self-checking bench for line_fifo with DATA_WIDTH=8, LINE_SIZE=4 and
// NUM_LINES=3. A behavioural model keeps committed words in a plain queue.
// The number of committed lines is derived from the words still unread.
// Directed scenarios are followed by a randomized phase.

module tb_line_fifo;

  localparam int DW = 8;
  localparam int LS = 4;
  localparam int NL = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          write;
  logic          line_abort;
  logic          read;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic [1:0]    lines_used;
  logic          overflow;
  logic [15:0]   drop_count;

  line_fifo #(
    .DATA_WIDTH(DW),
    .LINE_SIZE (LS),
    .NUM_LINES (NL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .write      (write),
    .line_abort (line_abort),
    .read       (read),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .lines_used (lines_used),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  // Reference model state.
  logic [DW-1:0] m_words[$];
  logic [DW-1:0] m_cur[$];
  bit            m_dropping;
  int            m_drop_pos;
  logic [DW-1:0] m_dout;
  bit            m_valid;
  bit            m_ovf;
  int            m_drops;

  int total   = 0;
  int bad     = 0;
  int step_no = 0;

  function automatic int m_lines();
    return (m_words.size() + LS - 1) / LS;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  // Applies the rules of one clock edge to the model.
  task automatic model_edge(input bit r, input bit w, input bit a, input bit rd,
                            input logic [DW-1:0] d);
    int pre;
    if (r) begin
      m_words.delete();
      m_cur.delete();
      m_dropping = 0;
      m_drop_pos = 0;
      m_dout     = '0;
      m_valid    = 0;
      m_ovf      = 0;
      m_drops    = 0;
      return;
    end
    pre   = m_lines();
    m_ovf = 0;
    if (rd && pre > 0) begin
      m_dout  = m_words.pop_front();
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    if (a) begin
      m_cur.delete();
      m_dropping = 0;
    end else if (w) begin
      if (m_dropping) begin
        m_drop_pos++;
        if (m_drop_pos == LS) begin
          m_dropping = 0;
          if (m_drops < 65535) m_drops++;
        end
      end else if (m_cur.size() == 0 && pre == NL) begin
        m_dropping = 1;
        m_drop_pos = 1;
        m_ovf      = 1;
      end else begin
        m_cur.push_back(d);
        if (m_cur.size() == LS) begin
          foreach (m_cur[i]) m_words.push_back(m_cur[i]);
          m_cur.delete();
        end
      end
    end
  endtask

  task automatic check_output();
    int exp_lines;
    int exp_dc;
    exp_lines = m_lines();
`ifdef LINE_FIFO_DROP_CNT_EN
    exp_dc = m_drops;
`else
    exp_dc = 0;
`endif
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("data_out",   32'(data_out),   32'(m_dout));
    check("lines_used", 32'(lines_used), 32'(exp_lines));
    check("empty",      32'(empty),      32'(exp_lines == 0));
    check("full",       32'(full),       32'(exp_lines == NL));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(exp_dc));
  endtask

  task automatic apply_stimulus(input bit r, input bit w, input bit a, input bit rd,
                                input logic [DW-1:0] d);
    reset      = r;
    write      = w;
    line_abort = a;
    read       = rd;
    data_in    = d;
    @(posedge clock);
    model_edge(r, w, a, rd, d);
    step_no++;
    #1;
    check_output();
  endtask

  task automatic write_line(input logic [DW-1:0] base);
    for (int i = 0; i < LS; i++) apply_stimulus(0, 1, 0, 0, base + DW'(i));
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 1, '0);
  endtask

  initial begin
    reset      = 1'b1;
    write      = 1'b0;
    line_abort = 1'b0;
    read       = 1'b0;
    data_in    = '0;

    $display("[TB] reset");
    apply_stimulus(1, 0, 0, 0, '0);
    apply_stimulus(1, 0, 0, 0, '0);
    apply_stimulus(0, 0, 0, 0, '0);

    $display("[TB] single line write and read");
    write_line(8'h11);
    read_words(4);
    apply_stimulus(0, 0, 0, 0, '0);
    check("empty_after_line", 32'(empty), 32'd1);

    $display("[TB] fill, overflow, read intact line");
    write_line(8'h20);
    write_line(8'h30);
    write_line(8'h40);
    check("full_after_three", 32'(full), 32'd1);
    write_line(8'h50);
    read_words(4);
    read_words(9);
    apply_stimulus(0, 0, 0, 0, '0);

    $display("[TB] abort with write in same cycle");
    apply_stimulus(0, 1, 0, 0, 8'h60);
    apply_stimulus(0, 1, 0, 0, 8'h61);
    apply_stimulus(0, 1, 1, 0, 8'h62);
    write_line(8'hA0);
    check("lines_after_abort", 32'(lines_used), 32'd1);
    read_words(4);
    apply_stimulus(0, 0, 0, 0, '0);

    $display("[TB] drop start coincides with read-line completion");
    write_line(8'h70);
    write_line(8'h80);
    write_line(8'h90);
    read_words(3);
    apply_stimulus(0, 1, 0, 1, 8'hB0);
    check("drop_on_shared_edge", 32'(overflow), 32'd1);
    for (int i = 1; i < LS; i++) apply_stimulus(0, 1, 0, 0, 8'hB0 + DW'(i));
    write_line(8'hC0);
    read_words(12);
    apply_stimulus(0, 0, 0, 0, '0);

    $display("[TB] reset mid-line");
    write_line(8'hD0);
    write_line(8'hE0);
    apply_stimulus(0, 1, 0, 0, 8'hF0);
    apply_stimulus(0, 1, 0, 0, 8'hF1);
    apply_stimulus(1, 1, 0, 1, 8'hF2);
    apply_stimulus(0, 0, 0, 0, '0);
    write_line(8'h55);
    read_words(4);
    apply_stimulus(0, 0, 0, 0, '0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 199) == 0,
                     $urandom_range(0, 9) < 7,
                     $urandom_range(0, 49) == 0,
                     $urandom_range(0, 9) < 4,
                     DW'($urandom));
    end
    read_words(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
